scd_loop_seq: RTL and testbench

- Loop/shift-count sequencer for the SCD shift-count register (SC).
- Loads SC from the SCAD result on `start`, then issues one shift/step strobe per EBOX cycle while decrementing SC by the step size.
- Stops when SC goes negative, the KL10 "count to −1" convention.
- Sequences SC for multiply, divide, normalize and shift loops on behalf of the microcode dispatch logic.

---
 rtl/scd_loop_seq_if.sv | 27 ++
 rtl/scd_loop_seq.sv | 95 +++++++++
 tb/tb_scd_loop_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/scd_loop_seq_if.sv
// Handshake and count bus between the microcode dispatch logic and the SC loop sequencer.
// The master drives loop requests and the slave reports SC and the step/done strobes.
interface scd_loop_seq_if #(
  parameter int SC_BITS = 10
);
  logic               start;
  logic [0:SC_BITS-1] count;
  logic               step2;
  logic               hold;
  logic               abort;
  logic [0:SC_BITS-1] SC;
  logic               SCsign;
  logic               busy;
  logic               step;
  logic               lastStep;
  logic               done;

  modport master (
    output start, count, step2, hold, abort,
    input  SC, SCsign, busy, step, lastStep, done
  );

  modport slave (
    input  start, count, step2, hold, abort,
    output SC, SCsign, busy, step, lastStep, done
  );
endinterface

// File: rtl/scd_loop_seq.sv
// SCD shift-count loop sequencer: loads SC, steps it down by 1 or 2 per EBOX cycle until it goes negative.
// Optional early termination is enabled with the SCD_LOOP_ABORT_EN macro.
module scd_loop_seq #(
  parameter int SC_BITS = 10
) (
  input logic         eboxClk,
  input logic         eboxReset,
  scd_loop_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [0:SC_BITS-1] sc_q, sc_d;
  logic               step2_q, step2_d;
  logic               step_q, step_d;
  logic               last_q, last_d;
  logic [0:SC_BITS-1] k_dec;
  logic               abort_hit;

`ifdef SCD_LOOP_ABORT_EN
  assign abort_hit = bus.abort;
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  assign k_dec = step2_q ? SC_BITS'(2) : SC_BITS'(1);

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state_q <= IDLE;
      sc_q    <= '0;
      step2_q <= 1'b0;
      step_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      step2_q <= step2_d;
      step_q  <= step_d;
      last_q  <= last_d;
    end
  end

  // The cycle after the final step is still RUN; it just hands over to DONE.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    step2_d = step2_q;
    step_d  = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sc_d = bus.count;
          if (bus.count[0]) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            step2_d = bus.step2;
          end
        end
      end
      RUN: begin
        if (last_q || abort_hit) begin
          state_d = DONE;
        end else if (!bus.hold) begin
          sc_d   = sc_q - k_dec;
          step_d = 1'b1;
          last_d = sc_d[0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.SC       = sc_q;
  assign bus.SCsign   = sc_q[0];
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.step     = step_q;
  assign bus.lastStep = last_q;

endmodule

// File: tb/tb_scd_loop_seq.sv
// Self-checking bench for scd_loop_seq: table-driven loops plus hand sequences for hold, reset and abort.
// A scoreboard queue holds the SC value and lastStep expected on every step strobe.
module tb_scd_loop_seq;

  localparam int SC_BITS = 10;

  typedef struct {
    logic [0:SC_BITS-1] count;
    logic               step2;
    int                 steps;
    logic [0:SC_BITS-1] final_sc;
    int                 cycles;
  } vec_t;

  typedef struct {
    logic [0:SC_BITS-1] sc;
    logic               last;
  } exp_t;

  logic eboxClk;
  logic eboxReset;

  scd_loop_seq_if #(.SC_BITS(SC_BITS)) bus ();

  scd_loop_seq #(.SC_BITS(SC_BITS)) dut (
    .eboxClk   (eboxClk),
    .eboxReset (eboxReset),
    .bus       (bus)
  );

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   step_cnt  = 0;
  int   cyc_cnt   = 0;
  int   last_cnt  = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  initial eboxClk = 1'b0;
  always #5 eboxClk = ~eboxClk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict every SC value the loop should show, using the count-to-minus-one rule.
  task automatic applyStimulus(input logic [0:SC_BITS-1] count, input logic step2);
    logic [0:SC_BITS-1] sc;
    logic [0:SC_BITS-1] k;
    exp_t               e;
    sc = count;
    k  = step2 ? SC_BITS'(2) : SC_BITS'(1);
    if (!count[0]) begin
      for (int i = 0; i < 2000; i++) begin
        sc     = sc - k;
        e.sc   = sc;
        e.last = sc[0];
        exp_q.push_back(e);
        if (sc[0]) break;
      end
    end
    step_cnt  = 0;
    cyc_cnt   = 0;
    last_cnt  = 0;
    bus.start = 1'b1;
    bus.count = count;
    bus.step2 = step2;
    @(negedge eboxClk);
    bus.start = 1'b0;
  endtask

  task automatic sampleCycle();
    exp_t e;
    cyc_cnt++;
    if (bus.step) begin
      step_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_step", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_sc", 32'(bus.SC), 32'(e.sc));
        checkOutput("sb_last", 32'(bus.lastStep), 32'(e.last));
      end
    end
    if (bus.lastStep) last_cnt++;
  endtask

  task automatic runLoop(input string name, input int exp_steps,
                         input logic [0:SC_BITS-1] exp_final, input int exp_cycles);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      if (i > 0) @(negedge eboxClk);
      sampleCycle();
      if (bus.done) fin = 1'b1;
    end
    checkOutput({name, "_completed"}, 32'(fin), 32'd1);
    checkOutput({name, "_steps"}, 32'(step_cnt), 32'(exp_steps));
    checkOutput({name, "_cycles"}, 32'(cyc_cnt), 32'(exp_cycles));
    checkOutput({name, "_final_sc"}, 32'(bus.SC), 32'(exp_final));
    checkOutput({name, "_scsign"}, 32'(bus.SCsign), 32'(exp_final[0]));
    checkOutput({name, "_done_busy"}, 32'(bus.busy), 32'd1);
    checkOutput({name, "_done_quiet"}, {30'd0, bus.step, bus.lastStep}, 32'd0);
    checkOutput({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge eboxClk);
    checkOutput({name, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{count: 10'h003, step2: 1'b0, steps: 4,   final_sc: 10'h3FF, cycles: 6};
    vecs[1] = '{count: 10'h006, step2: 1'b1, steps: 4,   final_sc: 10'h3FE, cycles: 6};
    vecs[2] = '{count: 10'h000, step2: 1'b1, steps: 1,   final_sc: 10'h3FE, cycles: 3};
    vecs[3] = '{count: 10'h000, step2: 1'b0, steps: 1,   final_sc: 10'h3FF, cycles: 3};
    vecs[4] = '{count: 10'h3FB, step2: 1'b0, steps: 0,   final_sc: 10'h3FB, cycles: 1};
    vecs[5] = '{count: 10'h001, step2: 1'b1, steps: 1,   final_sc: 10'h3FF, cycles: 3};
    vecs[6] = '{count: 10'h007, step2: 1'b1, steps: 4,   final_sc: 10'h3FF, cycles: 6};
    vecs[7] = '{count: 10'h1FF, step2: 1'b0, steps: 512, final_sc: 10'h3FF, cycles: 514};

    eboxReset = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    bus.step2 = 1'b0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge eboxClk);
    checkOutput("reset_sc", 32'(bus.SC), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_step", 32'(bus.step), 32'd0);
    checkOutput("reset_last", 32'(bus.lastStep), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    eboxReset = 1'b0;
    @(negedge eboxClk);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].count, vecs[v].step2);
      runLoop($sformatf("vec%0d", v), vecs[v].steps, vecs[v].final_sc, vecs[v].cycles);
    end

    // Hold after the first step, with a stray start that must be ignored.
    applyStimulus(10'h002, 1'b0);
    sampleCycle();
    @(negedge eboxClk);
    sampleCycle();
    checkOutput("hold_first_step", 32'(bus.step), 32'd1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge eboxClk);
      bus.start = 1'b0;
      sampleCycle();
      checkOutput("hold_no_step", 32'(bus.step), 32'd0);
      checkOutput("hold_sc_frozen", 32'(bus.SC), 32'h001);
      if (i == 1) begin
        bus.start = 1'b1;
        bus.count = 10'h100;
      end
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    @(negedge eboxClk);
    runLoop("hold_mid", 3, 10'h3FF, 8);

    // Hold on what would be the only (and last) step.
    bus.hold = 1'b1;
    applyStimulus(10'h000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge eboxClk);
      sampleCycle();
      checkOutput("hold_last_no_step", 32'(bus.step), 32'd0);
      checkOutput("hold_last_busy", 32'(bus.busy), 32'd1);
    end
    bus.hold = 1'b0;
    @(negedge eboxClk);
    runLoop("hold_last", 1, 10'h3FF, 5);

    // Reset in the middle of a loop clears at once and nothing follows.
    applyStimulus(10'h005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge eboxClk);
      sampleCycle();
    end
    checkOutput("rst_mid_steps_before", 32'(step_cnt), 32'd2);
    eboxReset = 1'b1;
    #1;
    checkOutput("rst_mid_sc", 32'(bus.SC), 32'd0);
    checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mid_step", 32'(bus.step), 32'd0);
    exp_q.delete();
    @(negedge eboxClk);
    eboxReset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge eboxClk);
      checkOutput("rst_mid_quiet", {30'd0, bus.step, bus.done}, 32'd0);
    end

    // Abort after three steps of a count=10 loop.
    applyStimulus(10'h00A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge eboxClk);
      sampleCycle();
    end
    checkOutput("abort_steps_before", 32'(step_cnt), 32'd3);
    bus.abort = 1'b1;
`ifdef SCD_LOOP_ABORT_EN
    exp_q.delete();
    @(negedge eboxClk);
    bus.abort = 1'b0;
    runLoop("abort_on", 3, 10'h007, 5);
`else
    @(negedge eboxClk);
    bus.abort = 1'b0;
    runLoop("abort_off", 11, 10'h3FF, 13);
`endif
    checkOutput("abort_last_count", 32'(last_cnt),
`ifdef SCD_LOOP_ABORT_EN
                32'd0);
`else
                32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
